// File: rtl/config_access_ctrl.sv
// Command sequencer between a valid/ready command port and a simple register file.
// One command is outstanding at a time: accept in IDLE, strobe the regfile in EXEC,
// wait one cycle for registered read data (RDWAIT), then hold the response in RESP.
module config_access_ctrl #(
  parameter bit ECHO_WRITES = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic [7:0]  write_addr,
  output logic [7:0]  write_data,
  output logic [7:0]  read_addr,
  output logic        write,
  output logic        read,
  output logic        load_config_defaults,
  input  logic [7:0]  read_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_op,
  output logic [7:0]  rsp_addr,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] txn_count
);

  localparam logic [1:0] OpRead    = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpLoadDef = 2'b10;
  localparam logic [1:0] OpIllegal = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StRdWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [7:0]  addr_q, data_q;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [15:0] txn_count_q, txn_count_d;
  logic        ready_q;
  logic        accept;

  // ready_q keeps cmd_ready low until the first clock edge after reset release.
  assign cmd_ready = ready_q && (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;

  // Next-state, response data and transaction count.
  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    txn_count_d = txn_count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        unique case (op_q)
          OpRead: state_d = StRdWait;
          OpWrite, OpLoadDef: begin
            rsp_data_d = (op_q == OpWrite) ? data_q : 8'h00;
            if (ECHO_WRITES) begin
              state_d = StResp;
            end else begin
              // Silent completion counts on EXEC exit since no handshake follows.
              state_d     = StIdle;
              txn_count_d = txn_count_q + 16'd1;
            end
          end
          OpIllegal: begin
            rsp_data_d = 8'h00;
            state_d    = StResp;
          end
          default: state_d = StIdle;
        endcase
      end
      StRdWait: begin
        rsp_data_d = read_data;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          txn_count_d = txn_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and response data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rsp_data_q  <= 8'h00;
      txn_count_q <= 16'h0000;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_data_q  <= rsp_data_d;
      txn_count_q <= txn_count_d;
      ready_q     <= 1'b1;
    end
  end

  // Command latch; holds the last accepted command while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= 2'b00;
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else if (accept) begin
      op_q   <= cmd_op;
      addr_q <= cmd_addr;
      data_q <= cmd_data;
    end
  end

  // Strobes and response outputs decode straight from state so reset clears them at once.
  always_comb begin
    read                 = (state_q == StExec) && (op_q == OpRead);
    write                = (state_q == StExec) && (op_q == OpWrite);
    load_config_defaults = (state_q == StExec) && (op_q == OpLoadDef);
    rsp_valid            = (state_q == StResp);
    rsp_err              = (state_q == StResp) && (op_q == OpIllegal);
    rsp_op               = op_q;
    rsp_addr             = addr_q;
    rsp_data             = rsp_data_q;
    write_addr           = addr_q;
    read_addr            = addr_q;
    write_data           = data_q;
    txn_count            = txn_count_q;
  end

endmodule

// File: tb/tb_config_access_ctrl.sv
// Bench for config_access_ctrl: an echoing instance with a regfile model attached and a
// silent (ECHO_WRITES=0) instance, checked against a high-level memory/count model.
module tb_config_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cmd_valid, s_cmd_valid, rsp_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr, cmd_data, read_data;
  logic        cmd_ready, write, read, load_config_defaults, rsp_valid, rsp_err;
  logic [7:0]  write_addr, write_data, read_addr, rsp_addr, rsp_data;
  logic [1:0]  rsp_op;
  logic [15:0] txn_count;
  logic        s_cmd_ready, s_write, s_read, s_load, s_rsp_valid, s_rsp_err;
  logic [7:0]  s_write_addr, s_write_data, s_read_addr, s_rsp_addr, s_rsp_data;
  logic [1:0]  s_rsp_op;
  logic [15:0] s_txn_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] ref_count;

  // Transaction observations filled by do_txn.
  logic [2:0] o_strobes;
  int         o_strobe_cnt, o_lat;
  logic [7:0] o_waddr, o_wdata, o_raddr, o_addr, o_data;
  logic [1:0] o_op;
  logic       o_err, o_stable, o_quiet, o_ready_after;
  logic [15:0] o_count;

  config_access_ctrl #(.ECHO_WRITES(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .write_addr(write_addr),
    .write_data(write_data), .read_addr(read_addr), .write(write), .read(read),
    .load_config_defaults(load_config_defaults), .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .txn_count(txn_count)
  );

  config_access_ctrl #(.ECHO_WRITES(1'b0)) dut_s (
    .clk(clk), .reset_n(reset_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .write_addr(s_write_addr),
    .write_data(s_write_data), .read_addr(s_read_addr), .write(s_write), .read(s_read),
    .load_config_defaults(s_load), .read_data(read_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_op(s_rsp_op), .rsp_addr(s_rsp_addr),
    .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .txn_count(s_txn_count)
  );

  function automatic logic [7:0] def_val(input int a);
    logic [7:0] v;
    v = a[7:0];
    return v ^ 8'h3C;
  endfunction

  // Register file model: registered read data, defaults loaded on reset or strobe.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= def_val(i);
      read_data <= 8'h00;
    end else begin
      if (read) read_data <= mem[read_addr];
      if (write) mem[write_addr] <= write_data;
      if (load_config_defaults) for (int i = 0; i < 256; i++) mem[i] <= def_val(i);
    end
  end

  // Issue one command to the echoing instance and record what it did.
  task automatic do_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input int hold, input bit early);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_data = 8'($urandom);
    if (early) rsp_ready = 1'b1;
    o_strobes = {read, write, load_config_defaults};
    o_strobe_cnt = {31'b0, read} + {31'b0, write} + {31'b0, load_config_defaults};
    o_waddr = write_addr; o_wdata = write_data; o_raddr = read_addr;
    k = 1;
    while (!rsp_valid && k < 8) begin
      @(negedge clk);
      k++;
      o_strobe_cnt += {31'b0, read} + {31'b0, write} + {31'b0, load_config_defaults};
    end
    o_lat = rsp_valid ? k : -1;
    o_op = rsp_op; o_addr = rsp_addr; o_data = rsp_data; o_err = rsp_err;
    o_stable = 1'b1; o_quiet = 1'b1;
    if (o_lat > 0) begin
      for (int i = 0; i < hold; i++) begin
        cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_addr = 8'($urandom);
        cmd_data = 8'($urandom);
        @(negedge clk);
        if (!rsp_valid || {rsp_op, rsp_addr, rsp_data, rsp_err} !== {o_op, o_addr, o_data, o_err})
          o_stable = 1'b0;
        if (cmd_ready || read || write || load_config_defaults) o_quiet = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    o_ready_after = cmd_ready && !rsp_valid;
    if (read || write || load_config_defaults) o_quiet = 1'b0;
    o_count = txn_count;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cmd_valid = 1'b0; s_cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = 8'h00; cmd_data = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = def_val(i);
    ref_count = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, write_addr, write_data, read_addr, write, read, load_config_defaults,
         rsp_valid, rsp_op, rsp_addr, rsp_data, rsp_err, txn_count} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs want all 0");
    end
    checks++;
    if ({s_cmd_ready, s_write_addr, s_write_data, s_read_addr, s_write, s_read, s_load,
         s_rsp_valid, s_rsp_op, s_rsp_addr, s_rsp_data, s_rsp_err, s_txn_count} !== '0) begin
      errors++; $display("FAIL reset_outputs_silent got nonzero outputs want all 0");
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b want 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready, s_cmd_ready, txn_count} !== {2'b11, 16'h0}) begin
      errors++;
      $display("FAIL ready_after_edge got %b%b cnt %h want 11 cnt 0000", cmd_ready, s_cmd_ready,
               txn_count);
    end
  endtask

  task automatic test_write_read;
    do_txn(2'b01, 8'h12, 8'hA5, 0, 1'b0);
    ref_mem[8'h12] = 8'hA5; ref_count++;
    checks++;
    if ({o_strobes, o_strobe_cnt} !== {3'b010, 32'd1}) begin
      errors++; $display("FAIL wr_strobe got %b/%0d want 010/1", o_strobes, o_strobe_cnt);
    end
    checks++;
    if ({o_waddr, o_wdata} !== 16'h12A5) begin
      errors++; $display("FAIL wr_drive got %h%h want 12a5", o_waddr, o_wdata);
    end
    checks++;
    if ({o_lat, o_data, o_err, o_count} !== {32'd2, 8'hA5, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL wr_rsp got lat %0d data %h err %b cnt %h want lat 2 data a5 err 0 cnt 1",
               o_lat, o_data, o_err, o_count);
    end
    do_txn(2'b00, 8'h12, 8'h00, 0, 1'b0);
    ref_count++;
    checks++;
    if ({o_strobes, o_raddr} !== {3'b100, 8'h12}) begin
      errors++; $display("FAIL rd_strobe got %b addr %h want 100 addr 12", o_strobes, o_raddr);
    end
    checks++;
    if ({o_lat, o_addr, o_data, o_op} !== {32'd3, 8'h12, 8'hA5, 2'b00}) begin
      errors++;
      $display("FAIL rd_rsp got lat %0d addr %h data %h op %b want lat 3 addr 12 data a5 op 00",
               o_lat, o_addr, o_data, o_op);
    end
  endtask

  task automatic test_hold;
    logic [7:0] a;
    a = 8'($urandom);
    do_txn(2'b00, a, 8'h00, 5, 1'b0);
    ref_count++;
    checks++;
    if ({o_stable, o_quiet, o_ready_after} !== 3'b111) begin
      errors++;
      $display("FAIL hold_stable got stable %b quiet %b ready %b want 111", o_stable, o_quiet,
               o_ready_after);
    end
    checks++;
    if ({o_data, o_count} !== {ref_mem[a], ref_count}) begin
      errors++;
      $display("FAIL hold_rsp got %h cnt %h want %h cnt %h", o_data, o_count, ref_mem[a],
               ref_count);
    end
  endtask

  task automatic test_illegal_load;
    do_txn(2'b11, 8'h40, 8'h77, 1, 1'b0);
    ref_count++;
    checks++;
    if ({o_strobe_cnt, o_lat, o_err, o_data, o_op} !== {32'd0, 32'd2, 1'b1, 8'h00, 2'b11}) begin
      errors++;
      $display("FAIL illegal got strobes %0d lat %0d err %b data %h want 0 2 1 00",
               o_strobe_cnt, o_lat, o_err, o_data);
    end
    do_txn(2'b10, 8'h12, 8'h99, 0, 1'b0);
    for (int i = 0; i < 256; i++) ref_mem[i] = def_val(i);
    ref_count++;
    checks++;
    if ({o_strobes, o_strobe_cnt, o_err, o_data} !== {3'b001, 32'd1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL load_def got %b/%0d err %b data %h want 001/1 err 0 data 00", o_strobes,
               o_strobe_cnt, o_err, o_data);
    end
    checks++;
    if (o_count !== ref_count) begin
      errors++; $display("FAIL load_count got %h want %h", o_count, ref_count);
    end
  endtask

  task automatic test_random;
    int sel, hold, exp_lat;
    bit early;
    logic [1:0] op;
    logic [7:0] a, d, exp_data;
    logic [2:0] exp_s;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b10 : 2'b11;
      a = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a = a | 8'hE0;
      d = 8'($urandom);
      hold = $urandom_range(0, 3);
      early = (hold == 0) && ($urandom_range(0, 1) == 1);
      exp_s = (op == 2'b00) ? 3'b100 : (op == 2'b01) ? 3'b010 : (op == 2'b10) ? 3'b001 : 3'b000;
      exp_lat = (op == 2'b00) ? 3 : 2;
      exp_data = (op == 2'b00) ? ref_mem[a] : (op == 2'b01) ? d : 8'h00;
      do_txn(op, a, d, hold, early);
      if (op == 2'b01) ref_mem[a] = d;
      if (op == 2'b10) for (int i = 0; i < 256; i++) ref_mem[i] = def_val(i);
      ref_count++;
      checks++;
      if ({o_strobes, o_strobe_cnt} !== {exp_s, (op == 2'b11) ? 32'd0 : 32'd1}) begin
        errors++; $display("FAIL rand_strobe #%0d got %b/%0d want %b", n, o_strobes,
                           o_strobe_cnt, exp_s);
      end
      checks++;
      if ({o_waddr, o_raddr, o_wdata} !== {a, a, d}) begin
        errors++; $display("FAIL rand_drive #%0d got %h %h %h want %h %h %h", n, o_waddr,
                           o_raddr, o_wdata, a, a, d);
      end
      checks++;
      if (o_lat !== exp_lat) begin
        errors++; $display("FAIL rand_latency #%0d got %0d want %0d", n, o_lat, exp_lat);
      end
      checks++;
      if ({o_op, o_addr, o_data, o_err} !== {op, a, exp_data, op == 2'b11}) begin
        errors++; $display("FAIL rand_rsp #%0d got %b %h %h %b want %b %h %h %b", n, o_op,
                           o_addr, o_data, o_err, op, a, exp_data, op == 2'b11);
      end
      checks++;
      if ({o_stable, o_quiet, o_ready_after} !== 3'b111) begin
        errors++; $display("FAIL rand_handshake #%0d got %b%b%b want 111", n, o_stable,
                           o_quiet, o_ready_after);
      end
      checks++;
      if (o_count !== ref_count) begin
        errors++; $display("FAIL rand_count #%0d got %h want %h", n, o_count, ref_count);
      end
    end
  endtask

  task automatic test_back_to_back_silent;
    logic [15:0] s_ref;
    logic [2:0]  exp_s;
    logic [7:0]  a, d;
    s_ref = 16'h0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); d = 8'($urandom);
      cmd_op = (i == 3) ? 2'b10 : 2'b01; cmd_addr = a; cmd_data = d;
      exp_s = (i == 3) ? 3'b001 : 3'b010;
      checks++;
      if (s_cmd_ready !== 1'b1) begin
        errors++; $display("FAIL silent_ready_t #%0d got %b want 1", i, s_cmd_ready);
      end
      s_cmd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({s_read, s_write, s_load, s_cmd_ready, s_rsp_valid} !== {exp_s, 2'b00}) begin
        errors++; $display("FAIL silent_exec #%0d got %b%b%b%b%b want %b00", i, s_read,
                           s_write, s_load, s_cmd_ready, s_rsp_valid, exp_s);
      end
      checks++;
      if ({s_write_addr, s_write_data} !== {a, d}) begin
        errors++; $display("FAIL silent_drive #%0d got %h%h want %h%h", i, s_write_addr,
                           s_write_data, a, d);
      end
      s_ref++;
      @(negedge clk);
      checks++;
      if ({s_cmd_ready, s_rsp_valid, s_txn_count} !== {2'b10, s_ref}) begin
        errors++; $display("FAIL silent_done #%0d got rdy %b vld %b cnt %h want 1 0 %h", i,
                           s_cmd_ready, s_rsp_valid, s_txn_count, s_ref);
      end
    end
    s_cmd_valid = 1'b0;
    force dut_s.txn_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut_s.txn_count_q;
    @(negedge clk);
    checks++;
    if (s_txn_count !== 16'hFFFF) begin
      errors++; $display("FAIL silent_preload got %h want ffff", s_txn_count);
    end
    cmd_op = 2'b01; s_cmd_valid = 1'b1;
    @(negedge clk);
    s_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_cmd_ready, s_rsp_valid, s_txn_count} !== {2'b10, 16'h0000}) begin
      errors++; $display("FAIL silent_wrap got rdy %b vld %b cnt %h want 1 0 0000",
                         s_cmd_ready, s_rsp_valid, s_txn_count);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] a;
    a = 8'($urandom_range(8, 200));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (txn_count !== ref_count) begin
      errors++; $display("FAIL mid_pre_count got %h want %h", txn_count, ref_count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({read, rsp_valid, cmd_ready, txn_count, read_addr} !== '0) begin
      errors++; $display("FAIL mid_async_reset got rd %b vld %b rdy %b cnt %h addr %h want 0",
                         read, rsp_valid, cmd_ready, txn_count, read_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = def_val(i);
    ref_count = 16'h0;
    do_txn(2'b00, a, 8'h00, 0, 1'b0);
    ref_count++;
    checks++;
    if ({o_strobes, o_lat, o_addr, o_data, o_count} !==
        {3'b100, 32'd3, a, ref_mem[a], ref_count}) begin
      errors++; $display("FAIL mid_fresh_read got %b lat %0d %h %h cnt %h want 100 3 %h %h %h",
                         o_strobes, o_lat, o_addr, o_data, o_count, a, ref_mem[a], ref_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_illegal_load();
    test_random();
    test_back_to_back_silent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
